// File: rtl/sram_bist_pkg.sv
// Shared types and per-element tables for the single-port SRAM March C- BIST.
package sram_bist_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_M0    = 4'd1,
        ST_M1    = 4'd2,
        ST_M2    = 4'd3,
        ST_M3    = 4'd4,
        ST_M4    = 4'd5,
        ST_M5    = 4'd6,
        ST_DRAIN = 4'd7,
        ST_DONE  = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_RD  = 2'd1,
        OP_WR  = 2'd2
    } op_e;

    // Descending elements walk N-1..0; all others walk 0..N-1.
    function automatic logic elem_down(input state_e s);
        return (s == ST_M3) || (s == ST_M4);
    endfunction

    // Elements with a read followed by a write at the same address.
    function automatic logic elem_two_op(input state_e s);
        return (s == ST_M1) || (s == ST_M2) || (s == ST_M3) || (s == ST_M4);
    endfunction

    // Background bit expected when reading in this element.
    function automatic logic rd_bit(input state_e s);
        return (s == ST_M2) || (s == ST_M4);
    endfunction

    // Background bit written in this element.
    function automatic logic wr_bit(input state_e s);
        return (s == ST_M1) || (s == ST_M3);
    endfunction

    // Memory operation issued in a given element and phase.
    function automatic op_e elem_op(input state_e s, input logic phase);
        op_e op;
        case (s)
            ST_M0:                      op = OP_WR;
            ST_M1, ST_M2, ST_M3, ST_M4: op = phase ? OP_WR : OP_RD;
            ST_M5:                      op = OP_RD;
            default:                    op = OP_NOP;
        endcase
        return op;
    endfunction

    // Element that follows the given one; the last element hands off to DRAIN.
    function automatic state_e next_elem(input state_e s);
        state_e n;
        case (s)
            ST_M0:   n = ST_M1;
            ST_M1:   n = ST_M2;
            ST_M2:   n = ST_M3;
            ST_M3:   n = ST_M4;
            ST_M4:   n = ST_M5;
            default: n = ST_DRAIN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/sram_bist_checker.sv
// Read-data checker: one-cycle expected/address pipeline, compare,
// first-fail capture and saturating mismatch counter.
module sram_bist_checker #(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    clr_i,
    input  logic                    rd_i,
    input  logic                    exp_bit_i,
    input  logic [P_ADDR_WIDTH-1:0] addr_i,
    input  logic [P_DATA_WIDTH-1:0] dout_i,
    output logic                    fail_o,
    output logic [P_ADDR_WIDTH-1:0] fail_addr_o,
    output logic [P_DATA_WIDTH-1:0] fail_syn_o,
    output logic [P_CNT_WIDTH-1:0]  err_cnt_o
);

    logic                    pend_q, pend_d;
    logic [P_DATA_WIDTH-1:0] exp_q, exp_d;
    logic [P_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic                    fail_q, fail_d;
    logic [P_ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic [P_DATA_WIDTH-1:0] fsyn_q, fsyn_d;
    logic [P_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [P_DATA_WIDTH-1:0] syn;
    logic                    mism;

    // Capture the read being issued now, and judge the one issued last cycle.
    always_comb begin
        pend_d  = rd_i;
        exp_d   = {P_DATA_WIDTH{exp_bit_i}};
        paddr_d = addr_i;
        fail_d  = fail_q;
        faddr_d = faddr_q;
        fsyn_d  = fsyn_q;
        cnt_d   = cnt_q;
        syn     = dout_i ^ exp_q;
        mism    = pend_q && (syn != '0);
        if (clr_i) begin
            fail_d  = 1'b0;
            faddr_d = '0;
            fsyn_d  = '0;
            cnt_d   = '0;
        end else if (mism) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + P_CNT_WIDTH'(1);
            end
            if (!fail_q) begin
                fail_d  = 1'b1;
                faddr_d = paddr_q;
                fsyn_d  = syn;
            end
        end
    end

    // Checker state registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            pend_q  <= 1'b0;
            exp_q   <= '0;
            paddr_q <= '0;
            fail_q  <= 1'b0;
            faddr_q <= '0;
            fsyn_q  <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            exp_q   <= exp_d;
            paddr_q <= paddr_d;
            fail_q  <= fail_d;
            faddr_q <= faddr_d;
            fsyn_q  <= fsyn_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fail_o      = fail_q;
    assign fail_addr_o = faddr_q;
    assign fail_syn_o  = fsyn_q;
    assign err_cnt_o   = cnt_q;

endmodule

// File: rtl/sram_1p_march_bist.sv
// March C- BIST initiator for the single-port SRAM macro: sequences the
// six elements over the whole address space and reports the result.
module sram_1p_march_bist
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14,
    parameter int P_CNT_WIDTH  = 16
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    start_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    fail_o,
    output logic [P_ADDR_WIDTH-1:0] fail_addr_o,
    output logic [P_DATA_WIDTH-1:0] fail_syn_o,
    output logic [P_CNT_WIDTH-1:0]  err_cnt_o,
    output logic [P_ADDR_WIDTH-1:0] A_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_DIN,
    output logic                    A_MEN,
    output logic                    A_WEN,
    output logic                    A_REN,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT
);

    state_e                  state_q, state_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                    phase_q, phase_d;
    logic [P_ADDR_WIDTH-1:0] last_addr;
    state_e                  nxt_elem;
    op_e                     op;
    logic                    start_acc;

    // Next-state: walk addresses within an element, then hand off to the next.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        phase_d   = phase_q;
        start_acc = 1'b0;
        last_addr = elem_down(state_q) ? '0 : '1;
        nxt_elem  = next_elem(state_q);
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    start_acc = 1'b1;
                    state_d   = ST_M0;
                    addr_d    = '0;
                    phase_d   = 1'b0;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                if (elem_two_op(state_q) && !phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == last_addr) begin
                        state_d = nxt_elem;
                        addr_d  = elem_down(nxt_elem) ? '1 : '0;
                    end else if (elem_down(state_q)) begin
                        addr_d = addr_q - P_ADDR_WIDTH'(1);
                    end else begin
                        addr_d = addr_q + P_ADDR_WIDTH'(1);
                    end
                end
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
        end
    end

    // Macro pins decode straight from registered state; read and write are exclusive.
    always_comb begin
        op     = elem_op(state_q, phase_q);
        A_ADDR = addr_q;
        A_MEN  = (op != OP_NOP);
        A_WEN  = (op == OP_WR);
        A_REN  = (op == OP_RD);
        A_DIN  = ((op == OP_WR) && wr_bit(state_q)) ? '1 : '0;
        busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_o = (state_q == ST_DONE);
    end

    sram_bist_checker #(
        .P_DATA_WIDTH (P_DATA_WIDTH),
        .P_ADDR_WIDTH (P_ADDR_WIDTH),
        .P_CNT_WIDTH  (P_CNT_WIDTH)
    ) u_checker (
        .clk         (A_CLK),
        .srst        (A_RST),
        .clr_i       (start_acc),
        .rd_i        (A_REN),
        .exp_bit_i   (rd_bit(state_q)),
        .addr_i      (addr_q),
        .dout_i      (A_DOUT),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_syn_o  (fail_syn_o),
        .err_cnt_o   (err_cnt_o)
    );

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// Scoreboard bench: stimulus queues expected macro ops and run results,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sram_1p_march_bist;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int CW = 3;
    localparam int N  = 1 << AW;
    localparam logic [1:0] K_RD = 2'b01;  // {WEN,REN}
    localparam logic [1:0] K_WR = 2'b10;

    logic          A_CLK = 1'b0;
    logic          A_RST = 1'b1;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, fail_o;
    logic [AW-1:0] fail_addr_o;
    logic [DW-1:0] fail_syn_o;
    logic [CW-1:0] err_cnt_o;
    logic [AW-1:0] A_ADDR;
    logic [DW-1:0] A_DIN;
    logic          A_MEN, A_WEN, A_REN;
    logic [DW-1:0] A_DOUT;

    sram_1p_march_bist #(
        .P_DATA_WIDTH (DW),
        .P_ADDR_WIDTH (AW),
        .P_CNT_WIDTH  (CW)
    ) dut (
        .A_CLK       (A_CLK),
        .A_RST       (A_RST),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .fail_o      (fail_o),
        .fail_addr_o (fail_addr_o),
        .fail_syn_o  (fail_syn_o),
        .err_cnt_o   (err_cnt_o),
        .A_ADDR      (A_ADDR),
        .A_DIN       (A_DIN),
        .A_MEN       (A_MEN),
        .A_WEN       (A_WEN),
        .A_REN       (A_REN),
        .A_DOUT      (A_DOUT)
    );

    always #5 A_CLK = ~A_CLK;

    typedef struct {
        logic [1:0]    kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
    } op_t;

    typedef struct {
        logic          fail;
        logic [AW-1:0] addr;
        logic [DW-1:0] syn;
        logic [CW-1:0] cnt;
        int            busy;
    } res_t;

    op_t  op_q[$];
    res_t res_q[$];
    int   rst_q[$];
    int   tests_run = 0;
    int   tests_failed = 0;
    int   fault_mode = 0;   // 0 none, 1 addr 5 bit 3 stuck-at-1, 2 every read inverted
    int   run_no = 0;

    // Behavioural macro with fault injection on the read path.
    logic [DW-1:0] mem [N];

    function automatic logic [DW-1:0] fault_f(input logic [DW-1:0] d, input logic [AW-1:0] a);
        if (fault_mode == 1 && a == 4'h5) return d | 8'h08;
        if (fault_mode == 2) return ~d;
        return d;
    endfunction

    always @(posedge A_CLK) begin
        if (A_MEN) begin
            if (A_WEN) mem[A_ADDR] <= A_DIN;
            else if (A_REN) A_DOUT <= fault_f(mem[A_ADDR], A_ADDR);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic push_op(input logic [1:0] k, input int a, input logic [DW-1:0] d);
        op_t o;
        o.kind = k;
        o.addr = AW'(a);
        o.din  = d;
        op_q.push_back(o);
    endtask

    // March C- op sequence written out element by element.
    task automatic push_run();
        for (int a = 0; a < N; a++) push_op(K_WR, a, 8'h00);
        for (int a = 0; a < N; a++) begin push_op(K_RD, a, 8'h00); push_op(K_WR, a, 8'hFF); end
        for (int a = 0; a < N; a++) begin push_op(K_RD, a, 8'h00); push_op(K_WR, a, 8'h00); end
        for (int a = N - 1; a >= 0; a--) begin push_op(K_RD, a, 8'h00); push_op(K_WR, a, 8'hFF); end
        for (int a = N - 1; a >= 0; a--) begin push_op(K_RD, a, 8'h00); push_op(K_WR, a, 8'h00); end
        for (int a = 0; a < N; a++) push_op(K_RD, a, 8'h00);
    endtask

    task automatic push_res(input logic f, input logic [AW-1:0] a, input logic [DW-1:0] s,
                            input logic [CW-1:0] c);
        res_t r;
        r.fail = f; r.addr = a; r.syn = s; r.cnt = c; r.busy = 10 * N + 1;
        res_q.push_back(r);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_o && n < 2000) begin
            @(posedge A_CLK); #1;
            n++;
        end
        if (n >= 2000) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL done_timeout: got done_o=%0b want 1", done_o);
        end
    endtask

    task automatic run_test(input int fm, input logic f, input logic [AW-1:0] a,
                            input logic [DW-1:0] s, input logic [CW-1:0] c);
        fault_mode = fm;
        push_run();
        push_res(f, a, s, c);
        start_i = 1'b1;
        @(posedge A_CLK); #1;
        start_i = 1'b0;
        wait_done();
        repeat (3) @(posedge A_CLK);
        #1;
    endtask

    // Monitor: compare ops, reset snapshots and end-of-run results.
    logic rst_d = 1'b0;
    int   busy_cnt = 0;
    logic done_prev = 1'b0;

    always @(posedge A_CLK) rst_d <= A_RST;

    always @(negedge A_CLK) begin
        if (rst_d) begin
            busy_cnt  = 0;
            done_prev = 1'b0;
            if (rst_q.size() > 0) begin
                void'(rst_q.pop_front());
                chk("reset_outputs",
                    {busy_o, done_o, fail_o, fail_addr_o, fail_syn_o, err_cnt_o,
                     A_MEN, A_WEN, A_REN, A_ADDR, A_DIN}, 64'd0);
                $display("[TB] reset: busy=%0b done=%0b fail=%0b cnt=%0d men=%0b",
                         busy_o, done_o, fail_o, err_cnt_o, A_MEN);
            end
        end else begin
            if (A_MEN) begin
                if (op_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_op: got addr=0x%0h wen=%0b ren=%0b want none",
                             A_ADDR, A_WEN, A_REN);
                end else begin
                    op_t e;
                    e = op_q.pop_front();
                    chk("op_kind", {A_WEN, A_REN}, e.kind);
                    chk("op_addr", A_ADDR, e.addr);
                    if (e.kind == K_WR) chk("op_din", A_DIN, e.din);
                end
            end
            if (busy_o) busy_cnt++;
            if (done_o && !done_prev) begin
                if (res_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL unexpected_done: got done_o=1 want 0");
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    run_no++;
                    $display("[TB] run %0d: fail=%0b addr=0x%0h syn=0x%0h cnt=%0d busy_cycles=%0d",
                             run_no, fail_o, fail_addr_o, fail_syn_o, err_cnt_o, busy_cnt);
                    chk("res_fail", fail_o, r.fail);
                    chk("res_fail_addr", fail_addr_o, r.addr);
                    chk("res_fail_syn", fail_syn_o, r.syn);
                    chk("res_err_cnt", err_cnt_o, r.cnt);
                    chk("res_busy_cycles", busy_cnt, r.busy);
                end
                busy_cnt = 0;
            end
            done_prev = done_o;
        end
    end

    initial begin
        rst_q.push_back(1);
        A_RST = 1'b1;
        repeat (3) @(posedge A_CLK);
        #1 A_RST = 1'b0;
        repeat (2) @(posedge A_CLK);
        #1;

        run_test(0, 1'b0, 4'h0, 8'h00, 3'd0);   // clean
        run_test(1, 1'b1, 4'h5, 8'h08, 3'd3);   // stuck-at-1, addr 5 bit 3
        run_test(2, 1'b1, 4'h0, 8'hFF, 3'd7);   // every read fails, counter saturates
        run_test(0, 1'b0, 4'h0, 8'h00, 3'd0);   // restart from DONE clears results

        // Reset 50 cycles into a run.
        fault_mode = 0;
        push_run();
        start_i = 1'b1;
        @(posedge A_CLK); #1;
        start_i = 1'b0;
        repeat (49) @(posedge A_CLK);
        #1;
        A_RST = 1'b1;
        rst_q.push_back(1);
        @(posedge A_CLK); #1;
        A_RST = 1'b0;
        op_q.delete();
        repeat (2) @(posedge A_CLK);
        #1;
        run_test(0, 1'b0, 4'h0, 8'h00, 3'd0);   // full clean run after reset

        // start_i held high: exactly two back-to-back runs, no restart while busy.
        fault_mode = 0;
        push_run(); push_res(1'b0, 4'h0, 8'h00, 3'd0);
        push_run(); push_res(1'b0, 4'h0, 8'h00, 3'd0);
        start_i = 1'b1;
        @(posedge A_CLK); #1;
        wait_done();
        @(posedge A_CLK); #1;
        wait_done();
        start_i = 1'b0;
        repeat (10) @(posedge A_CLK);
        #1;

        chk("ops_left", op_q.size(), 0);
        chk("results_left", res_q.size(), 0);
        chk("final_done", done_o, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
